// File: rtl/command_tx_buf.sv
// command_tx_buf: host-to-device data buffer of the SATA command layer.
// The application layer writes dwords into a 1k x 32 RAM. A start command
// arms a frame of N dwords, which then stream to the transport layer through
// a one-entry prefetch stage. The block also reports level, overflow,
// underrun and frame completion.
module command_tx_buf #(
   parameter int ADDR_W = 10,
   parameter int LEN_W  = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       al_data_in,
   input  logic              al_data_val_in,
   input  logic [LEN_W-1:0]  al_frame_len_in,
   input  logic              al_frame_start_in,
   input  logic              al_abort_in,
   output logic [ADDR_W:0]   al_level_out,
   output logic              al_full_out,
   output logic              al_busy_out,
   output logic              al_overflow_out,
   output logic              al_underrun_out,
   output logic              al_frame_done_out,
   output logic [31:0]       tl_data_out,
   output logic              tl_data_val_out,
   output logic              tl_data_last_out,
   input  logic              tl_data_strobe_in
);

   localparam int               DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W:0]  FULL_LVL = (ADDR_W+1)'(DEPTH);
   localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(2048);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   waddr_q;
   logic [ADDR_W-1:0]   raddr_q;
   logic [ADDR_W:0]     level_q;
   logic [ADDR_W:0]     level_d;
   logic [LEN_W-1:0]    remaining_q;
   logic                pf_valid_q;
   logic                out_seen_q;
   logic                overflow_q;
   logic                underrun_q;
   logic                done_q;

   logic [31:0]         mem [DEPTH];
   logic [31:0]         rd_data_q;

   logic                full;
   logic                present;
   logic                wr_en;
   logic                pop;
   logic                load;
   logic                start_ok;
   logic [ADDR_W:0]     ram_count;

   // Handshake decode. The level counts the prefetch entry as well, so the
   // dwords still sitting in RAM are the level minus the prefetch flag.
   always_comb begin
      full      = (level_q == FULL_LVL);
      present   = (state_q == STREAM) && pf_valid_q;
      wr_en     = al_data_val_in && !full && !al_abort_in;
      pop       = present && tl_data_strobe_in && !al_abort_in;
      ram_count = level_q - {{ADDR_W{1'b0}}, pf_valid_q};
      load      = (ram_count != '0) && (!pf_valid_q || pop) && !al_abort_in;
      start_ok  = (state_q == IDLE) && al_frame_start_in && !al_abort_in &&
                  (al_frame_len_in != '0) && (al_frame_len_in <= MAX_LEN);
      level_d   = level_q + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(pop);
   end

   // RAM write port.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[waddr_q] <= al_data_in;
      end
   end

   // Registered RAM read; this register is the prefetch data, refilled only
   // when it is empty or being popped so the presented dword holds otherwise.
   always_ff @(posedge clk) begin
      if (load) begin
         rd_data_q <= mem[raddr_q];
      end
   end

   // Pointers, level, prefetch flag, frame FSM and status flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         waddr_q     <= '0;
         raddr_q     <= '0;
         level_q     <= '0;
         remaining_q <= '0;
         pf_valid_q  <= 1'b0;
         out_seen_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underrun_q  <= 1'b0;
         done_q      <= 1'b0;
      end else if (al_abort_in) begin
         state_q     <= IDLE;
         waddr_q     <= '0;
         raddr_q     <= '0;
         level_q     <= '0;
         remaining_q <= '0;
         pf_valid_q  <= 1'b0;
         out_seen_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underrun_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         level_q <= level_d;
         if (wr_en) begin
            waddr_q <= waddr_q + 1'b1;
         end
         if (load) begin
            raddr_q    <= raddr_q + 1'b1;
            pf_valid_q <= 1'b1;
            out_seen_q <= 1'b1;
         end else if (pop) begin
            pf_valid_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (start_ok) begin
                  state_q     <= STREAM;
                  remaining_q <= al_frame_len_in;
                  overflow_q  <= 1'b0;
                  underrun_q  <= 1'b0;
               end
            end
            STREAM: begin
               if (tl_data_strobe_in && !pf_valid_q) begin
                  underrun_q <= 1'b1;
               end
               if (pop) begin
                  remaining_q <= remaining_q - 1'b1;
                  if (remaining_q == LEN_W'(1)) begin
                     state_q <= IDLE;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
         // Placed after the start handling so a dropped write in a start
         // cycle still leaves overflow set.
         if (al_data_val_in && full) begin
            overflow_q <= 1'b1;
         end
      end
   end

   assign al_level_out      = level_q;
   assign al_full_out       = full;
   assign al_busy_out       = (state_q == STREAM);
   assign al_overflow_out   = overflow_q;
   assign al_underrun_out   = underrun_q;
   assign al_frame_done_out = done_q;
   assign tl_data_out       = out_seen_q ? rd_data_q : 32'h0;
   assign tl_data_val_out   = present;
   assign tl_data_last_out  = present && (remaining_q == LEN_W'(1));

endmodule

// File: tb/tb_command_tx_buf.sv
// Testbench for command_tx_buf: directed scenarios plus a randomized phase,
// checked by a queue-based reference model and a separate output monitor.
module tb_command_tx_buf;

   localparam int ADDR_W = 10;
   localparam int LEN_W  = 12;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [31:0]       al_data_in = '0;
   logic              al_data_val_in = 1'b0;
   logic [LEN_W-1:0]  al_frame_len_in = '0;
   logic              al_frame_start_in = 1'b0;
   logic              al_abort_in = 1'b0;
   logic [ADDR_W:0]   al_level_out;
   logic              al_full_out;
   logic              al_busy_out;
   logic              al_overflow_out;
   logic              al_underrun_out;
   logic              al_frame_done_out;
   logic [31:0]       tl_data_out;
   logic              tl_data_val_out;
   logic              tl_data_last_out;
   logic              tl_data_strobe_in = 1'b0;

   command_tx_buf #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk               (clk),
      .rst               (rst),
      .al_data_in        (al_data_in),
      .al_data_val_in    (al_data_val_in),
      .al_frame_len_in   (al_frame_len_in),
      .al_frame_start_in (al_frame_start_in),
      .al_abort_in       (al_abort_in),
      .al_level_out      (al_level_out),
      .al_full_out       (al_full_out),
      .al_busy_out       (al_busy_out),
      .al_overflow_out   (al_overflow_out),
      .al_underrun_out   (al_underrun_out),
      .al_frame_done_out (al_frame_done_out),
      .tl_data_out       (tl_data_out),
      .tl_data_val_out   (tl_data_val_out),
      .tl_data_last_out  (tl_data_last_out),
      .tl_data_strobe_in (tl_data_strobe_in)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: buffered dwords in write order, pending frame lengths,
   // and the frame/flag state implied by the stimulus.
   logic [31:0] exp_data[$];
   int          exp_len[$];
   int          rem_m     = 0;
   bit          busy_m    = 1'b0;
   bit          ovf_m     = 1'b0;
   bit          done_pend = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      exp_data.delete();
      exp_len.delete();
      rem_m     = 0;
      busy_m    = 1'b0;
      ovf_m     = 1'b0;
      done_pend = 1'b0;
   endtask

   // One clock cycle: check the registered status against the model, drive
   // the inputs, update the model, then advance to just after the next edge.
   task automatic cyc(input bit wr, input logic [31:0] d, input bit st,
                      input int len, input bit ab, input bit sb);
      chk("level", 32'(al_level_out), 32'(exp_data.size()));
      chk("full", 32'(al_full_out), 32'(exp_data.size() == 1024));
      chk("busy", 32'(al_busy_out), 32'(busy_m));
      chk("overflow", 32'(al_overflow_out), 32'(ovf_m));
      al_data_val_in    = wr;
      al_data_in        = d;
      al_frame_start_in = st;
      al_frame_len_in   = LEN_W'(len);
      al_abort_in       = ab;
      tl_data_strobe_in = sb;
      if (ab) begin
         model_clear();
      end else begin
         if (st && !busy_m && len >= 1 && len <= 2048) begin
            busy_m = 1'b1;
            ovf_m  = 1'b0;
            exp_len.push_back(len);
         end
         if (wr) begin
            if (exp_data.size() < 1024) exp_data.push_back(d);
            else ovf_m = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0);
   endtask

   // Hold the strobe until the armed frame completes; optionally keep feeding
   // fresh dwords so a frame longer than the buffered data can finish.
   task automatic drain(input int budget, input bit feed);
      int n = 0;
      while (busy_m && n < budget) begin
         cyc(feed && exp_data.size() < 1024, $urandom, 1'b0, 0, 1'b0, 1'b1);
         n++;
      end
      checks++;
      if (busy_m) begin
         errors++;
         $display("FAIL drain_timeout: frame still busy after %0d cycles, required idle", budget);
      end
   endtask

   // Monitor: every consumed dword is compared with the head of the model.
   always @(negedge clk) begin
      logic [31:0] exp_word;
      if (rst && !al_abort_in) begin
         if (done_pend || al_frame_done_out) chk("frame_done", 32'(al_frame_done_out), 32'(done_pend));
         done_pend = 1'b0;
         if (tl_data_last_out && !tl_data_val_out) chk("last_without_val", 32'(tl_data_last_out), 32'h0);
         if (tl_data_val_out && !busy_m) chk("val_outside_frame", 32'(tl_data_val_out), 32'h0);
         if (tl_data_val_out && tl_data_strobe_in) begin
            if (rem_m == 0 && exp_len.size() != 0) rem_m = exp_len.pop_front();
            if (rem_m == 0 || exp_data.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_dword: got %h with none expected", tl_data_out);
            end else begin
               exp_word = exp_data.pop_front();
               chk("tl_data", tl_data_out, exp_word);
               chk("tl_last", 32'(tl_data_last_out), 32'(rem_m == 1));
               rem_m--;
               if (rem_m == 0) begin
                  busy_m    = 1'b0;
                  done_pend = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      bit seen;
      // Reset values
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_level", 32'(al_level_out), 32'h0);
      chk("rst_val", 32'(tl_data_val_out), 32'h0);
      chk("rst_busy", 32'(al_busy_out), 32'h0);
      chk("rst_data", tl_data_out, 32'h0);
      rst = 1'b1;
      idle(2);

      // 1) Preloaded frame streams back to back
      for (int i = 0; i < 4; i++) cyc(1'b1, 32'hA0 + 32'(i), 1'b0, 0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b1, 4, 1'b0, 1'b1);
      chk("t1_first_data", tl_data_out, 32'hA0);
      for (int i = 0; i < 4; i++) begin
         chk("t1_val_back_to_back", 32'(tl_data_val_out), 32'h1);
         cyc(1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b1);
      end
      chk("t1_done", 32'(al_frame_done_out), 32'h1);
      chk("t1_val_after", 32'(tl_data_val_out), 32'h0);
      chk("t1_underrun", 32'(al_underrun_out), 32'h0);
      idle(1);
      chk("t1_done_single", 32'(al_frame_done_out), 32'h0);

      // 2) Frame armed on an empty buffer, data trickles in
      cyc(1'b0, 32'h0, 1'b1, 3, 1'b0, 1'b1);
      cyc(1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b1);
      chk("t2_underrun", 32'(al_underrun_out), 32'h1);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 32'hB0 + 32'(i), 1'b0, 0, 1'b0, 1'b1);
         cyc(1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b1);
         seen = tl_data_val_out;
         cyc(1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b1);
         seen |= tl_data_val_out;
         chk("t2_latency", 32'(seen), 32'h1);
      end
      idle(2);
      chk("t2_underrun_sticky", 32'(al_underrun_out), 32'h1);

      // 3) Overfill with no frame armed
      for (int i = 0; i < 1025; i++) cyc(1'b1, 32'h3000_0000 + 32'(i), 1'b0, 0, 1'b0, 1'b0);
      idle(1);
      chk("t3_level", 32'(al_level_out), 32'd1024);
      chk("t3_full", 32'(al_full_out), 32'h1);
      chk("t3_overflow", 32'(al_overflow_out), 32'h1);
      cyc(1'b0, 32'h0, 1'b1, 1024, 1'b0, 1'b1);
      drain(1100, 1'b0);
      idle(2);
      chk("t3_level_empty", 32'(al_level_out), 32'h0);
      chk("t3_underrun", 32'(al_underrun_out), 32'h0);

      // 4) Surplus dwords carried into the next frame
      for (int i = 0; i < 6; i++) cyc(1'b1, 32'hC0 + 32'(i), 1'b0, 0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b1, 4, 1'b0, 1'b1);
      drain(20, 1'b0);
      idle(1);
      chk("t4_level_surplus", 32'(al_level_out), 32'd2);
      cyc(1'b0, 32'h0, 1'b1, 2, 1'b0, 1'b1);
      drain(20, 1'b0);
      idle(2);

      // 5) Abort mid-frame, then illegal starts, then a clean frame
      for (int i = 0; i < 8; i++) cyc(1'b1, 32'hD0 + 32'(i), 1'b0, 0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b1, 8, 1'b0, 1'b1);
      cyc(1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b1);
      cyc(1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b1);
      cyc(1'b1, 32'hDEAD, 1'b0, 0, 1'b1, 1'b1);
      chk("t5_val", 32'(tl_data_val_out), 32'h0);
      chk("t5_busy", 32'(al_busy_out), 32'h0);
      chk("t5_level", 32'(al_level_out), 32'h0);
      for (int i = 0; i < 3; i++) begin
         chk("t5_no_done", 32'(al_frame_done_out), 32'h0);
         idle(1);
      end
      cyc(1'b0, 32'h0, 1'b1, 0, 1'b0, 1'b0);
      idle(1);
      chk("t5_len0_ignored", 32'(al_busy_out), 32'h0);
      cyc(1'b0, 32'h0, 1'b1, 2049, 1'b0, 1'b0);
      idle(1);
      chk("t5_len2049_ignored", 32'(al_busy_out), 32'h0);
      cyc(1'b1, 32'hE0, 1'b0, 0, 1'b0, 1'b0);
      cyc(1'b1, 32'hE1, 1'b0, 0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b1, 2, 1'b0, 1'b1);
      drain(20, 1'b0);
      idle(2);

      // 6) Asynchronous reset between edges during a frame
      for (int i = 0; i < 4; i++) cyc(1'b1, 32'hF0 + 32'(i), 1'b0, 0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b1, 4, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0);
      chk("t6_streaming", 32'(tl_data_val_out), 32'h1);
      #2;
      rst = 1'b0;
      #1;
      chk("t6_level", 32'(al_level_out), 32'h0);
      chk("t6_busy", 32'(al_busy_out), 32'h0);
      chk("t6_val", 32'(tl_data_val_out), 32'h0);
      chk("t6_last", 32'(tl_data_last_out), 32'h0);
      chk("t6_data", tl_data_out, 32'h0);
      chk("t6_flags", {28'h0, al_full_out, al_overflow_out, al_underrun_out, al_frame_done_out}, 32'h0);
      model_clear();
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle(1);

      // Wrap: a short frame offsets the pointers so a 512-dword frame
      // crosses address 1023 -> 0 mid-stream.
      for (int i = 0; i < 100; i++) cyc(1'b1, 32'h5000_0000 + 32'(i), 1'b0, 0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b1, 100, 1'b0, 1'b1);
      drain(200, 1'b0);
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < 512; i++)
            cyc(1'b1, 32'h6000_0000 + 32'(f << 16) + 32'(i), 1'b0, 0, 1'b0, 1'b0);
         cyc(1'b0, 32'h0, 1'b1, 512, 1'b0, 1'b1);
         drain(600, 1'b0);
      end
      idle(2);

      // Randomized traffic with occasional illegal starts and aborts
      for (int c = 0; c < 4000; c++) begin
         bit wr;
         bit st;
         bit ab;
         bit sb;
         int len;
         wr  = ($urandom_range(0, 99) < 55);
         st  = !busy_m && ($urandom_range(0, 7) == 0);
         len = $urandom_range(1, 300);
         if ($urandom_range(0, 19) == 0) len = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(2049, 4095);
         ab  = ($urandom_range(0, 499) == 0);
         sb  = ($urandom_range(0, 99) < 70);
         cyc(wr, $urandom, st, len, ab, sb);
      end
      drain(3000, 1'b1);
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
